packet_rr_arbiter: RTL and testbench

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

---
 rtl/rrarb_pkg.sv | 21 ++
 rtl/arbitration_algorithm.sv | 23 ++
 rtl/packet_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_packet_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rrarb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package rrarb_pkg;

  localparam int unsigned RRARB_MAX_REQ = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rrarb_state_e;

  // Binary index of the set bit in a one-hot vector (zero for an all-zero vector).
  function automatic logic [31:0] onehot_to_idx(input logic [RRARB_MAX_REQ-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < RRARB_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitration_algorithm.sv
// Combinational round-robin pick: lowest valid requester strictly above the
// previous one-hot grant, else the lowest valid requester overall.
module arbitration_algorithm #(
  parameter int N = 8
) (
  input  logic [N-1:0] input_valid,
  input  logic [N-1:0] current_ready,
  output logic [N-1:0] grant
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] above_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] pick_src;

  // An all-zero current_ready yields an empty mask, so the pick falls back to lowest overall.
  assign above_mask = ~(current_ready | (current_ready - ONE));
  assign upper_req  = input_valid & above_mask;
  assign pick_src   = (|upper_req) ? upper_req : input_valid;
  assign grant      = pick_src & (~pick_src + ONE);

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: N_REQ beat streams merged into one
// registered output; a requester keeps the grant from first beat to its last beat.
module packet_rr_arbiter
  import rrarb_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int DATAW = 64,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*DATAW-1:0] in_data,
  input  logic [N_REQ-1:0]       in_last,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [DATAW-1:0]       out_data,
  output logic                   out_last,
  output logic [IDW-1:0]         out_id,
  input  logic                   out_ready
);

  rrarb_state_e     state_q, state_d;
  logic [N_REQ-1:0] last_grant_q, last_grant_d;
  logic [N_REQ-1:0] lock_grant_q, lock_grant_d;
  logic [N_REQ-1:0] rr_grant;
  logic [N_REQ-1:0] grant;
  logic             slot_free;
  logic             accept;
  logic [DATAW-1:0] sel_data;
  logic             sel_last;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q;
  logic             out_last_q;
  logic [IDW-1:0]   out_id_q;

  arbitration_algorithm #(.N(N_REQ)) u_arb (
    .input_valid   (in_valid),
    .current_ready (last_grant_q),
    .grant         (rr_grant)
  );

  assign grant     = (state_q == LOCKED) ? lock_grant_q : rr_grant;
  assign slot_free = !out_valid_q || out_ready;
  // Gating with rst keeps the asynchronous reset window free of accepts.
  assign in_ready  = rst ? '0 : (grant & {N_REQ{slot_free}});
  assign accept    = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*DATAW +: DATAW];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_grant_d = lock_grant_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d      = LOCKED;
          lock_grant_d = grant;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d      = IDLE;
          lock_grant_d = '0;
        end
      end
    endcase
    // Priority only rotates when a packet completes.
    if (accept && sel_last) last_grant_d = grant;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= {1'b1, {(N_REQ-1){1'b0}}};
      lock_grant_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_grant_q <= lock_grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_data_q <= sel_data;
        out_last_q <= sel_last;
        out_id_q   <= IDW'(onehot_to_idx(RRARB_MAX_REQ'(grant)));
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Randomized and directed bench for packet_rr_arbiter against a transaction-level model.
module tb_packet_rr_arbiter;

  localparam int N  = 8;
  localparam int DW = 64;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [2:0]      out_id;
  logic            out_ready;

  packet_rr_arbiter #(.N_REQ(N), .DATAW(DW), .IDW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: integer requester ids, one output slot.
  bit          m_locked;
  int          m_lock;
  int          m_last;
  bit          m_ov;
  bit          m_ol;
  logic [63:0] m_od;
  int          m_oid;

  // Per-requester packet generators.
  int g_beat[N];
  int g_len[N];
  int g_pkt[N];
  bit g_lenset[N];

  int idq[$];
  int dq[$];
  int handoffs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] beat_data(input int i);
    logic [7:0]  id8;
    logic [15:0] p16;
    logic [15:0] b16;
    id8 = i[7:0];
    p16 = g_pkt[i][15:0];
    b16 = g_beat[i][15:0];
    return {24'hC0FFEE, id8, p16, b16};
  endfunction

  task automatic step(input logic [N-1:0] vmask, input int pv, input int pr,
                      input int maxlen, input int fixlen);
    int gid;
    bit sf;
    bit acc;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!g_lenset[i]) begin
        g_len[i]    = (fixlen > 0) ? fixlen : 1 + int'($urandom_range(maxlen - 1, 0));
        g_lenset[i] = 1'b1;
      end
      in_valid[i]         = vmask[i] && (int'($urandom_range(99, 0)) < pv);
      in_last[i]          = (g_beat[i] == g_len[i] - 1);
      in_data[i*DW +: DW] = beat_data(i);
    end
    out_ready = (int'($urandom_range(99, 0)) < pr);
    #1;
    sf      = !m_ov || out_ready;
    gid     = m_locked ? m_lock : rr_pick(in_valid, m_last);
    exp_rdy = '0;
    acc     = 1'b0;
    if (gid >= 0 && sf) begin
      exp_rdy = N'(1) << gid;
      acc     = in_valid[gid];
    end
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_last", 64'(out_last), 64'(m_ol));
      chk("out_id", 64'(out_id), 64'(m_oid));
    end
    if (out_valid) idq.push_back(int'(out_id));
    if (out_valid && out_ready) begin
      handoffs++;
      dq.push_back(int'(out_data[15:0]));
    end
    if (acc) begin
      m_od  = in_data[gid*DW +: DW];
      m_ol  = in_last[gid];
      m_oid = gid;
      m_ov  = 1'b1;
      if (in_last[gid]) begin
        m_locked      = 1'b0;
        m_last        = gid;
        g_beat[gid]   = 0;
        g_lenset[gid] = 1'b0;
        g_pkt[gid]++;
      end else begin
        m_locked = 1'b1;
        m_lock   = gid;
        g_beat[gid]++;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    in_valid  = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    m_locked  = 1'b0;
    m_lock    = 0;
    m_last    = N - 1;
    m_ov      = 1'b0;
    for (int i = 0; i < N; i++) begin
      g_beat[i]   = 0;
      g_lenset[i] = 1'b0;
    end
    idq.delete();
    dq.delete();
    handoffs = 0;
  endtask

  task automatic chk_ids(input string tag, input int k, input int exp);
    chk($sformatf("%s_%0d", tag, k), (k < idq.size()) ? 64'(idq[k]) : 64'hFFFF, 64'(exp));
  endtask

  initial begin
    int e34[5];
    int e35[5];
    int e37[5];
    rst       = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) g_pkt[i] = 0;

    // Two requesters, single-beat packets: strict alternation.
    do_reset();
    repeat (6) step(8'h81, 100, 100, 1, 0);
    e34 = '{0, 7, 0, 7, 0};
    for (int k = 0; k < 5; k++) chk_ids("alt_ids", k, e34[k]);

    // 4-beat packet from 2 keeps the grant while 5 waits.
    do_reset();
    repeat (7) step(8'h24, 100, 100, 1, 4);
    e35 = '{2, 2, 2, 2, 5};
    for (int k = 0; k < 5; k++) chk_ids("lock_ids", k, e35[k]);

    // Backpressure mid-packet: nothing lost or duplicated.
    do_reset();
    repeat (2) step(8'h08, 100, 100, 1, 6);
    repeat (3) step(8'h08, 100, 0, 1, 6);
    repeat (4) step(8'h08, 100, 100, 1, 6);
    repeat (3) step(8'h00, 100, 100, 1, 6);
    chk("stall_handoffs", 64'(handoffs), 64'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("stall_beat_%0d", k), (k < dq.size()) ? 64'(dq[k]) : 64'hFFFF, 64'(k));

    // Locked requester drops valid; the other requester must wait.
    do_reset();
    step(8'h18, 100, 100, 1, 4);
    repeat (2) step(8'h10, 100, 100, 1, 4);
    repeat (6) step(8'h18, 100, 100, 1, 4);
    e37 = '{3, 3, 3, 3, 4};
    for (int k = 0; k < 5; k++) chk_ids("gap_ids", k, e37[k]);

    // All requesters valid, single beats: full rotation.
    do_reset();
    repeat (11) step(8'hFF, 100, 100, 1, 0);
    for (int k = 0; k < 9; k++) chk_ids("rot_ids", k, k % 8);

    // Reset during a locked packet.
    do_reset();
    repeat (3) step(8'h40, 100, 100, 1, 5);
    do_reset();
    repeat (3) step(8'hC0, 100, 100, 1, 5);
    chk_ids("post_rst_id", 0, 6);

    // Randomized traffic.
    do_reset();
    repeat (2500) step(8'hFF, 60, 70, 4, 0);
    repeat (2500) step(8'hFF, 90, 30, 6, 0);
    repeat (1000) step(N'($urandom), 80, 80, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
